// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph patterns (bit0=a .. bit6=g) and capture FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'h3F;
  localparam logic [6:0] SEG7_1     = 7'h06;
  localparam logic [6:0] SEG7_2     = 7'h5B;
  localparam logic [6:0] SEG7_3     = 7'h4F;
  localparam logic [6:0] SEG7_4     = 7'h66;
  localparam logic [6:0] SEG7_5     = 7'h6D;
  localparam logic [6:0] SEG7_6     = 7'h7D;
  localparam logic [6:0] SEG7_7     = 7'h07;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h6F;
  localparam logic [6:0] SEG7_A     = 7'h77;
  localparam logic [6:0] SEG7_B     = 7'h7C;
  localparam logic [6:0] SEG7_C     = 7'h39;
  localparam logic [6:0] SEG7_D     = 7'h5E;
  localparam logic [6:0] SEG7_E     = 7'h79;
  localparam logic [6:0] SEG7_F     = 7'h71;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the glyph table: pattern -> hex digit, legal and blank flags.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    digit = 4'h0;
    legal = 1'b1;
    blank = 1'b0;
    case (pattern)
      SEG7_0:     digit = 4'h0;
      SEG7_1:     digit = 4'h1;
      SEG7_2:     digit = 4'h2;
      SEG7_3:     digit = 4'h3;
      SEG7_4:     digit = 4'h4;
      SEG7_5:     digit = 4'h5;
      SEG7_6:     digit = 4'h6;
      SEG7_7:     digit = 4'h7;
      SEG7_8:     digit = 4'h8;
      SEG7_9:     digit = 4'h9;
      SEG7_A:     digit = 4'hA;
      SEG7_B:     digit = 4'hB;
      SEG7_C:     digit = 4'hC;
      SEG7_D:     digit = 4'hD;
      SEG7_E:     digit = 4'hE;
      SEG7_F:     digit = 4'hF;
      SEG7_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Samples an asynchronous 7-segment bus, waits for a stable pattern, then decodes it.
// fsm_state exposes the capture FSM for checkers.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 5,
  parameter int unsigned ACTIVE_LOW    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       err_clr,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       digit_strobe,
  output logic       blank,
  output logic       pattern_err,
  output logic [7:0] change_count,
  output logic [1:0] fsm_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]  seg_fix;
  logic [6:0]  s1;
  logic [6:0]  s2;
  logic [6:0]  candidate;
  logic [6:0]  accepted;
  logic [CNT_W-1:0] cnt;
  logic        have_acc;
  seg7_state_e state;

  logic [3:0]  dec_digit;
  logic        dec_legal;
  logic        dec_blank;

  assign seg_fix   = (ACTIVE_LOW != 0) ? ~seg_in : seg_in;
  assign fsm_state = state;

  // Decode the candidate so outputs land on the same edge that accepts it.
  seg7_pattern_decode u_decode (
    .pattern (candidate),
    .digit   (dec_digit),
    .legal   (dec_legal),
    .blank   (dec_blank)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1           <= '0;
      s2           <= '0;
      candidate    <= '0;
      accepted     <= '0;
      cnt          <= '0;
      have_acc     <= 1'b0;
      state        <= WAIT;
      digit        <= '0;
      digit_valid  <= 1'b0;
      digit_strobe <= 1'b0;
      blank        <= 1'b0;
      pattern_err  <= 1'b0;
      change_count <= '0;
    end else begin
      s1 <= seg_fix;
      s2 <= s1;

      if (s2 != candidate) begin
        candidate <= s2;
        cnt       <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      digit_strobe <= 1'b0;
      if (err_clr) pattern_err <= 1'b0;

      case (state)
        WAIT: begin
          if (s2 != accepted) state <= SETTLE;
        end
        SETTLE: begin
          // A reversion is a filtered glitch; fall back to wherever we came from.
          if (candidate == accepted) begin
            state <= have_acc ? LOCKED : WAIT;
          end else if (cnt == CNT_MAX) begin
            state        <= LOCKED;
            have_acc     <= 1'b1;
            accepted     <= candidate;
            digit_strobe <= 1'b1;
            change_count <= change_count + 8'd1;
            if (dec_legal) begin
              digit       <= dec_digit;
              digit_valid <= 1'b1;
              blank       <= 1'b0;
            end else if (dec_blank) begin
              digit_valid <= 1'b0;
              blank       <= 1'b1;
            end else begin
              digit_valid <= 1'b0;
              blank       <= 1'b0;
              pattern_err <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (candidate != accepted) state <= SETTLE;
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder: one active-high and one active-low instance, STABLE_CYCLES=4.
module tb_seg7_capture_decoder;

  logic       clk;
  logic       rst_n;
  logic       err_clr;
  logic [6:0] seg_a;
  logic [6:0] seg_b;

  logic [3:0] digit_a, digit_b;
  logic       valid_a, valid_b;
  logic       strobe_a, strobe_b;
  logic       blank_a, blank_b;
  logic       err_a, err_b;
  logic [7:0] count_a, count_b;
  logic [1:0] state_a, state_b;

  int compared;
  int mismatched;
  int strobes_a;
  int strobes_b;
  int base;

  logic [6:0] glyphs [16];
  logic [3:0] exp_q [$];

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg7_capture_decoder #(.STABLE_CYCLES(4), .CNT_W(5), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_a), .err_clr(err_clr),
    .digit(digit_a), .digit_valid(valid_a), .digit_strobe(strobe_a),
    .blank(blank_a), .pattern_err(err_a), .change_count(count_a),
    .fsm_state(state_a)
  );

  seg7_capture_decoder #(.STABLE_CYCLES(4), .CNT_W(5), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_b), .err_clr(err_clr),
    .digit(digit_b), .digit_valid(valid_b), .digit_strobe(strobe_b),
    .blank(blank_b), .pattern_err(err_b), .change_count(count_b),
    .fsm_state(state_b)
  );

  // Strobe tally: the pre-edge strobe value is seen at each rising edge.
  initial begin
    strobes_a = 0;
    strobes_b = 0;
  end
  always @(posedge clk) begin
    if (strobe_a) strobes_a++;
    if (strobe_b) strobes_b++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic hold_a(input logic [6:0] pat, input int n);
    seg_a = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_digit"},  {4'h0, digit_a}, 8'h00);
    chk({tag, "_valid"},  {7'h0, valid_a}, 8'h00);
    chk({tag, "_strobe"}, {7'h0, strobe_a}, 8'h00);
    chk({tag, "_blank"},  {7'h0, blank_a}, 8'h00);
    chk({tag, "_err"},    {7'h0, err_a}, 8'h00);
    chk({tag, "_count"},  count_a, 8'h00);
    chk({tag, "_state"},  {6'h0, state_a}, 8'h00);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    glyphs = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst_n   = 1'b0;
    err_clr = 1'b0;
    seg_a   = 7'h00;
    seg_b   = 7'h7F;
    repeat (3) @(negedge clk);
    chk_zero_a("reset");

    // First acceptance: strobe exactly in the cycle after edge 6.
    rst_n = 1'b1;
    seg_a = 7'h06;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_strobe", {7'h0, strobe_a}, (k == 6) ? 8'h01 : 8'h00);
      chk("t1_valid",  {7'h0, valid_a},  (k >= 6) ? 8'h01 : 8'h00);
    end
    chk("t1_digit", {4'h0, digit_a}, 8'h01);
    chk("t1_count", count_a, 8'h01);
    chk("t1_state", {6'h0, state_a}, 8'h02);
    chk("t1_strobes", 8'(strobes_a), 8'h01);

    // Walk all 16 glyphs.
    for (int i = 0; i < 16; i++) begin
      base = strobes_a;
      exp_q.push_back(4'(i));
      hold_a(glyphs[i], 10);
      chk("walk_digit", {4'h0, digit_a}, {4'h0, exp_q.pop_front()});
      chk("walk_valid", {7'h0, valid_a}, 8'h01);
      chk("walk_strobe_n", 8'(strobes_a - base), 8'h01);
    end
    chk("walk_count", count_a, 8'd17);

    // Short glitch is filtered.
    hold_a(7'h4F, 10);
    base = strobes_a;
    hold_a(7'h7F, 2);
    hold_a(7'h4F, 10);
    chk("glitch_strobes", 8'(strobes_a - base), 8'h00);
    chk("glitch_digit", {4'h0, digit_a}, 8'h03);
    chk("glitch_count", count_a, 8'd18);

    // Illegal pattern and sticky error.
    base = strobes_a;
    hold_a(7'h49, 10);
    chk("illegal_strobes", 8'(strobes_a - base), 8'h01);
    chk("illegal_valid", {7'h0, valid_a}, 8'h00);
    chk("illegal_blank", {7'h0, blank_a}, 8'h00);
    chk("illegal_err", {7'h0, err_a}, 8'h01);
    chk("illegal_digit", {4'h0, digit_a}, 8'h03);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("errclr_err", {7'h0, err_a}, 8'h00);
    hold_a(7'h06, 10);
    chk("legal_err", {7'h0, err_a}, 8'h00);
    seg_a   = 7'h49;
    err_clr = 1'b1;
    repeat (6) @(negedge clk);
    chk("setwins_pre_err", {7'h0, err_a}, 8'h00);
    @(negedge clk);
    err_clr = 1'b0;
    chk("setwins_err", {7'h0, err_a}, 8'h01);
    chk("setwins_digit", {4'h0, digit_a}, 8'h01);
    chk("setwins_count", count_a, 8'd21);

    // Active-low instance.
    seg_b = 7'h40;
    repeat (10) @(negedge clk);
    chk("al_digit", {4'h0, digit_b}, 8'h00);
    chk("al_valid", {7'h0, valid_b}, 8'h01);
    chk("al_strobes", 8'(strobes_b), 8'h01);
    seg_b = 7'h7F;
    repeat (10) @(negedge clk);
    chk("al_blank", {7'h0, blank_b}, 8'h01);
    chk("al_blank_valid", {7'h0, valid_b}, 8'h00);
    chk("al_blank_err", {7'h0, err_b}, 8'h00);
    chk("al_count", count_b, 8'd2);

    // change_count wrap from a fresh reset.
    rst_n = 1'b0;
    seg_a = 7'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = strobes_a;
    for (int i = 0; i < 256; i++) begin
      hold_a((i % 2 == 1) ? 7'h5B : 7'h06, 8);
      if (i == 254) chk("wrap_255", count_a, 8'd255);
    end
    chk("wrap_count", count_a, 8'h00);
    chk("wrap_strobes", 8'((strobes_a - base) % 256), 8'h00);
    chk("wrap_strobes_hi", 8'((strobes_a - base) / 256), 8'h01);
    chk("wrap_digit", {4'h0, digit_a}, 8'h02);

    // Reset mid-settle discards the candidate.
    hold_a(7'h3F, 4);
    chk("midsettle_state", {6'h0, state_a}, 8'h01);
    rst_n = 1'b0;
    seg_a = 7'h00;
    @(negedge clk);
    chk_zero_a("midrst");
    rst_n = 1'b1;
    base = strobes_a;
    repeat (15) @(negedge clk);
    chk("midrst_strobes", 8'(strobes_a - base), 8'h00);
    chk("midrst_valid", {7'h0, valid_a}, 8'h00);
    chk("midrst_count", count_a, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
Receive-side counterpart of the team's digit-to-7-segment encoder. It samples an external 7-segment drive bus and synchronises it. It waits for the pattern to stay stable, then decodes it back to a 4-bit hex digit with a valid level and a one-cycle strobe. Used on loopback and inter-board links to read back what a neighbouring display driver is showing, and to flag illegal segment patterns.

Parameters:
STABLE_CYCLES, 16, consecutive identical synchronised samples required before a pattern is accepted; legal range is at least 2.
CNT_W, 5, width of the stability counter; must satisfy 2**CNT_W > STABLE_CYCLES.
ACTIVE_LOW, 0, when 1 the seg_in bits are inverted before any processing (common-anode displays).

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
seg_in  input  7  raw segment bus, bit0=a .. bit6=g, asynchronous to clk
err_clr  input  1  clears the sticky pattern_err
digit  output  4  last accepted decoded digit
digit_valid  output  1  high while the accepted pattern is a legal hex glyph
digit_strobe  output  1  one-cycle pulse when a new pattern is accepted
blank  output  1  high while the accepted pattern is 0x00
pattern_err  output  1  sticky flag: an illegal non-blank pattern was accepted
change_count  output  8  count of accepted pattern changes, wraps

Behaviour:
- Reset values: all outputs 0. Synchroniser flops 0, candidate 0, counter 0, accepted pattern 0, state WAIT.
- Input path: optional inversion when ACTIVE_LOW=1, then a 2-flop synchroniser (s1, s2). Only s2 is used downstream.
- Stability tracking:
  - If s2 differs from candidate: candidate <= s2, cnt <= 0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES-1.
- States:
  - WAIT: after reset, nothing accepted yet. Go to SETTLE on the first s2 that differs from the accepted pattern (0x00).
  - SETTLE: counting. When cnt==STABLE_CYCLES-1 and candidate differs from the accepted pattern, accept on that edge and go to LOCKED. If candidate reverts to the accepted pattern, go to LOCKED with no strobe (glitch filtered); from WAIT this reversion returns to WAIT.
  - LOCKED: go to SETTLE whenever candidate differs from the accepted pattern.
- Acceptance (single edge):
  - accepted <= candidate.
  - digit_strobe = 1 for exactly the next cycle.
  - change_count += 1, wrapping 255 -> 0.
- Decoding of the accepted pattern (bits g..a), pattern -> digit:
  - 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3
  - 0x66->4, 0x6D->5, 0x7D->6, 0x07->7
  - 0x7F->8, 0x6F->9, 0x77->A, 0x7C->b
  - 0x39->C, 0x5E->d, 0x79->E, 0x71->F
- Decode outputs:
  - Legal glyph: digit updates, digit_valid=1, blank=0.
  - 0x00: blank=1, digit_valid=0, digit holds its previous value, no error.
  - Any other pattern: digit_valid=0, blank=0, digit holds, pattern_err set.
- Latency: seg_in changes before edge 0 and then stays constant. digit, digit_valid and digit_strobe update at edge STABLE_CYCLES+2.
- pattern_err:
  - Sticky; cleared by err_clr=1 at a clock edge.
  - If err_clr coincides with an accepting edge whose pattern is illegal, set wins.
- A strobe is issued even when the newly accepted pattern is blank or illegal.
- Re-accepting the same pattern never happens: no strobe and no count while the bus is steady.
- rst_n low mid-settle discards candidate and count. The first post-reset s2 value reaches s2 at edge 2 after reset is released.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16 glyph constants (SEG7_0..SEG7_F) and SEG7_BLANK, reused by the encoder;
  - the state enum (WAIT, SETTLE, LOCKED).
- One combinational sub-module, seg7_pattern_decode: 7-bit pattern in; digit, legal and blank out.

Test Plan:
- Reset, then hold seg_in=0x06 with STABLE_CYCLES=4 -> digit_strobe pulses in the cycle after edge 6; digit=1, digit_valid=1, change_count=1.
- Step through 0x3F..0x71 (all 16 glyphs), each held 10 cycles -> digits 0..F in order, 16 strobes, change_count=17 including the first test's count (or 16 from a fresh reset).
- From LOCKED on 0x4F, apply a 2-cycle glitch to 0x7F, then back to 0x4F -> no strobe, digit stays 3, change_count unchanged.
- Apply 0x49 (illegal) -> strobe, digit_valid=0, pattern_err=1, digit holds the prior value. Pulse err_clr -> pattern_err=0. Apply 0x49 again with err_clr held high at the accepting edge -> pattern_err=1.
- Set ACTIVE_LOW=1 and drive 0x40 (inverted 0x3F) -> digit=0, digit_valid=1. Drive 0x7F (inverted 0x00) -> blank=1, digit_valid=0, no error.
- Perform 256 alternating accepts between 0x06 and 0x5B -> change_count wraps to 0. Assert rst_n=0 mid-settle -> all outputs 0 on the next edge, and no strobe from the discarded candidate.
